// File: rtl/hazard_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tracker
//
// Hazard-resolution stage sitting right after the D-stage address/timing
// calculator of the 5-stage MIPS pipeline. Every write that leaves D is
// tracked through E, M and W together with its Tnew countdown. The D-stage
// operand reads are checked against those in-flight writes to decide whether
// the front end must stall and where each operand should be forwarded from.
//
// Parameters
//   TUSE_NONE : Tuse code meaning "this operand is not read"
//   CNT_W     : width of the stall performance counter
//
// Ports
//   clk          in   pipeline clock, rising edge
//   reset        in   asynchronous active-low reset
//   RAddr0/1     in   D-stage operand register addresses (Rs / Rt)
//   Tuse_RAddr0/1 in  cycles from D until each operand is consumed
//   WAddr        in   D-stage destination register (0 = no write)
//   Tnew_WAddr   in   cycles from E entry until the result exists
//   Stall        out  freeze F/D and inject a bubble into E
//   FwdSel0/1    out  D-stage operand source: 0 RF, 1 E, 2 M, 3 W
//   StallCnt     out  number of cycles in which Stall was high (wraps)
// ---------------------------------------------------------------------------
module hazard_tracker #(
    parameter logic [2:0]  TUSE_NONE = 3'd7,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RAddr0,
    input  logic [4:0]       RAddr1,
    input  logic [2:0]       Tuse_RAddr0,
    input  logic [2:0]       Tuse_RAddr1,
    input  logic [4:0]       WAddr,
    input  logic [2:0]       Tnew_WAddr,
    output logic             Stall,
    output logic [1:0]       FwdSel0,
    output logic [1:0]       FwdSel1,
    output logic [CNT_W-1:0] StallCnt
);

    // Stage slots: write address and remaining Tnew for E, M and W.
    logic [4:0]       e_wa_r, m_wa_r, w_wa_r;
    logic [2:0]       e_tn_r, m_tn_r, w_tn_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // {hazard, forward select} for each operand.
    logic [2:0]       res0_s, res1_s;
    logic             stall_s;

    // Saturating 3-bit decrement of the Tnew countdown.
    function automatic logic [2:0] dec(input logic [2:0] x);
        logic [2:0] r;
        if (x == 3'd0) begin
            r = 3'd0;
        end else begin
            r = x - 3'd1;
        end
        return r;
    endfunction

    // Outcome for a matching slot: hazard if the result is later than the
    // consumer needs it; forward only once the value actually exists.
    function automatic logic [2:0] pick(input logic [2:0] tn,
                                        input logic [2:0] tuse,
                                        input logic [1:0] code);
        logic [2:0] r;
        r[2] = (tn > tuse);
        if (tn == 3'd0) begin
            r[1:0] = code;
        end else begin
            r[1:0] = 2'd0;
        end
        return r;
    endfunction

    // Youngest-first search (E, then M, then W). $0 and unused operands
    // never match, so they can neither stall nor forward.
    function automatic logic [2:0] resolve(input logic [4:0] raddr,
                                           input logic [2:0] tuse,
                                           input logic [4:0] ewa, input logic [2:0] etn,
                                           input logic [4:0] mwa, input logic [2:0] mtn,
                                           input logic [4:0] wwa, input logic [2:0] wtn);
        logic       active;
        logic [2:0] r;
        active = (raddr != 5'd0) && (tuse != TUSE_NONE);
        if (active && (ewa != 5'd0) && (ewa == raddr)) begin
            r = pick(etn, tuse, 2'd1);
        end else if (active && (mwa != 5'd0) && (mwa == raddr)) begin
            r = pick(mtn, tuse, 2'd2);
        end else if (active && (wwa != 5'd0) && (wwa == raddr)) begin
            r = pick(wtn, tuse, 2'd3);
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Combinational hazard detection and forward selection for both operands.
    always_comb begin
        res0_s  = resolve(RAddr0, Tuse_RAddr0, e_wa_r, e_tn_r, m_wa_r, m_tn_r, w_wa_r, w_tn_r);
        res1_s  = resolve(RAddr1, Tuse_RAddr1, e_wa_r, e_tn_r, m_wa_r, m_tn_r, w_wa_r, w_tn_r);
        stall_s = res0_s[2] | res1_s[2];
    end

    // Pipeline slot advance; a stall turns the E entry into a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_wa_r <= 5'd0;
            e_tn_r <= 3'd0;
            m_wa_r <= 5'd0;
            m_tn_r <= 3'd0;
            w_wa_r <= 5'd0;
            w_tn_r <= 3'd0;
        end else begin
            w_wa_r <= m_wa_r;
            w_tn_r <= dec(m_tn_r);
            m_wa_r <= e_wa_r;
            m_tn_r <= dec(e_tn_r);
            if (stall_s) begin
                e_wa_r <= 5'd0;
                e_tn_r <= 3'd0;
            end else begin
                e_wa_r <= WAddr;
                e_tn_r <= Tnew_WAddr;
            end
        end
    end

    // Stall performance counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign Stall    = stall_s;
    assign FwdSel0  = res0_s[1:0];
    assign FwdSel1  = res1_s[1:0];
    assign StallCnt = stall_cnt_r;

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Hazard-resolution stage directly downstream of the D-stage address/timing calculator in the 5-stage MIPS pipeline. Takes the D-stage operand addresses with their Tuse values and the write address with its Tnew value. Tracks every in-flight write through E, M and W with a per-cycle Tnew countdown. Drives the pipeline stall, the D-stage operand forward selects and a stall performance counter.

## Interface
- `TUSE_NONE`, 3'd7: Tuse code meaning the operand is not read.
- `CNT_W`, 32: width of the stall counter.

- `clk` input 1: pipeline clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `RAddr0` input 5: D-stage operand 0 (Rs) register address.
- `RAddr1` input 5: D-stage operand 1 (Rt) register address.
- `Tuse_RAddr0` input 3: cycles from D until operand 0 is consumed.
- `Tuse_RAddr1` input 3: cycles from D until operand 1 is consumed.
- `WAddr` input 5: D-stage destination register. 0 means no write.
- `Tnew_WAddr` input 3: cycles from E entry until the result exists.
- `Stall` output 1: freeze F/D and inject a bubble into E.
- `FwdSel0` output 2: D-stage source for operand 0. 0 = RF, 1 = E, 2 = M, 3 = W.
- `FwdSel1` output 2: same encoding for operand 1.
- `StallCnt` output CNT_W: number of cycles in which `Stall` was 1.

## Operation
- **State.** Three stage slots E, M and W, each holding {WA[4:0], TN[2:0]}. Reset value of every slot is {0, 0}.
- **Advance on every rising edge.** Global enable is always on; `Stall` only selects what enters E.
  - W ← {M.WA, dec(M.TN)}.
  - M ← {E.WA, dec(E.TN)}.
  - E ← {0, 0} (bubble) if `Stall`=1, else {`WAddr`, `Tnew_WAddr`}.
  - dec(x) = 0 when x = 0, else x − 1. Saturating, 3-bit.
  - The W slot contents are discarded on the next edge.
- **Match rule, per operand k.** Slot S matches when RAddrk ≠ 0, Tuse_RAddrk ≠ TUSE_NONE, S.WA ≠ 0 and S.WA = RAddrk.
- **Youngest wins.** Search order is E, then M, then W. Only the first matching slot counts.
  - Operand k hazard = youngest match exists and its TN > Tuse_RAddrk.
  - FwdSelk = stage code of the youngest match when its TN = 0.
  - FwdSelk = 0 otherwise, including when there is no match or the youngest match has TN > 0.
  - When the youngest match has 0 < TN ≤ Tuse, no stall is raised. Late forwarding is done by the E/M forward muxes, which are outside this block.
- **Stall** = hazard0 OR hazard1.
- **StallCnt** increments by 1 on each edge where `Stall`=1. It wraps modulo 2^CNT_W.
- **Register $0.** Writes to $0 and reads of $0 never stall and never forward.

## Timing
- `Stall`, `FwdSel0` and `FwdSel1` are combinational from the slots and the D inputs, valid in the same cycle. No input-to-output registers.
- Slot and counter updates take effect one edge after the inputs are sampled.
- Reset asserted at any time, including mid-stall:
  - All slots become {0, 0} and StallCnt becomes 0 immediately, without waiting for `clk`.
  - `Stall`=0 and FwdSel=0 for as long as the D inputs carry no match.
- Deassertion of `reset` is synchronised externally. The first edge after release performs a normal advance.
- A load followed by a consumer with Tuse=0 costs exactly 2 stall cycles. A load followed by a consumer with Tuse=1 costs exactly 1 stall cycle.
- Both operands hazarding in the same cycle raises a single `Stall`. StallCnt advances by 1.

## Test plan
- **Reset mid-stall.** lw $8 in E with Tnew=2 and beq reading $8, then drive `reset`=0 between edges. Required: `Stall` and StallCnt drop to 0 without a `clk` edge, and all slots read {0, 0}.
- **Load then branch.** lw (WAddr=8, Tnew=2) followed by beq (RAddr0=8, Tuse=0). Required: `Stall`=1 for 2 cycles, then `Stall`=0 with FwdSel0=3, and StallCnt=2.
- **ALU then ALU.** addu (WAddr=9, Tnew=1) followed by addu (RAddr1=9, Tuse=1). Required: `Stall`=0 throughout and FwdSel1=0.
- **lui then jr.** lui (WAddr=4, Tnew=0) followed by jr (RAddr0=4, Tuse=0). Required: `Stall`=0 and FwdSel0=1.
- **Youngest wins.** E={8, 0} and M={8, 0}, with RAddr0=8 and Tuse=0. Required: FwdSel0=1. Then set E={8, 1}: required `Stall`=1 even though M holds TN=0.
- **Register $0 and unused operands.** WAddr=0 with Tnew=2 followed by RAddr0=0 and Tuse=0: required `Stall`=0 and FwdSel0=0. A read with Tuse=7 matching E={5, 2}: required `Stall`=0.
